// File: rtl/rename_regfile_pkg.sv
// Shared rename constants and types used by the register file, ROB and issue unit.
package rename_regfile_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned Q_WIDTH        = 4;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned NUM_REGS       = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [Q_WIDTH-1:0]        tag_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  // Tag 0 is never a live ROB slot and marks a register as not renamed.
  localparam tag_t NO_TAG = '0;

  typedef struct packed {
    logic  busy;
    tag_t  tag;
    data_t value;
  } read_resp_t;

endpackage

// File: rtl/rename_read_port.sv
// Combinational operand lookup with same-cycle commit bypass.
module rename_read_port
  import rename_regfile_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0]              addr_i,
  input  logic [NUM_REGS-1:0]                    busy_i,
  input  logic [NUM_REGS-1:0][Q_WIDTH-1:0]       tag_i,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    value_i,
  input  logic                                   commit_valid_i,
  input  logic [Q_WIDTH-1:0]                     commit_q_i,
  input  logic [DATA_WIDTH-1:0]                  commit_v_i,
  output read_resp_t                             resp_c
);

  always_comb begin
    resp_c = '0;
    if (addr_i == REG_ADDR_WIDTH'(0)) begin
      resp_c = '0;
    end else if (busy_i[addr_i] && commit_valid_i && (commit_q_i == tag_i[addr_i])) begin
      // Producer retires this cycle: hand its value straight to the reader.
      resp_c.value = commit_v_i;
    end else if (busy_i[addr_i]) begin
      resp_c.busy = 1'b1;
      resp_c.tag  = tag_i[addr_i];
    end else begin
      resp_c.value = value_i[addr_i];
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags.
module rename_regfile
  import rename_regfile_pkg::*;
(
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr,
  output logic                       rs1_busy,
  output logic [Q_WIDTH-1:0]         rs1_Q,
  output logic [DATA_WIDTH-1:0]      rs1_V,
  output logic                       rs2_busy,
  output logic [Q_WIDTH-1:0]         rs2_Q,
  output logic [DATA_WIDTH-1:0]      rs2_V,
  input  logic                       has_issue,
  input  logic [REG_ADDR_WIDTH-1:0]  issue_rd,
  input  logic [Q_WIDTH-1:0]         issue_Q,
  input  logic                       commit_modify_regfile,
  input  logic [REG_ADDR_WIDTH-1:0]  commit_reg_addr,
  input  logic [Q_WIDTH-1:0]         Commit_Q,
  input  logic [DATA_WIDTH-1:0]      Commit_V,
  input  logic                       control_hazard,
  output logic [31:0]                commit_count
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] value_q, value_d;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;
  logic [NUM_REGS-1:0][Q_WIDTH-1:0]    tag_q, tag_d;
  logic [31:0]                         count_q, count_d;

  read_resp_t rs1_resp, rs2_resp;

  // Commit first, then flush or issue; a same-cycle issue overrides the commit's tag clear.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    count_d = count_q;
    if (rdy_in) begin
      if (commit_modify_regfile) begin
        if (commit_reg_addr != REG_ADDR_WIDTH'(0)) begin
          value_d[commit_reg_addr] = Commit_V;
        end
        if (busy_q[commit_reg_addr] && (tag_q[commit_reg_addr] == Commit_Q)) begin
          busy_d[commit_reg_addr] = 1'b0;
          tag_d[commit_reg_addr]  = NO_TAG;
        end
        count_d = count_q + 32'd1;
      end
      if (control_hazard) begin
        busy_d = '0;
        tag_d  = '0;
      end else if (has_issue && (issue_rd != REG_ADDR_WIDTH'(0))) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_Q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

  rename_read_port u_rs1 (
    .addr_i         (rs1_addr),
    .busy_i         (busy_q),
    .tag_i          (tag_q),
    .value_i        (value_q),
    .commit_valid_i (commit_modify_regfile),
    .commit_q_i     (Commit_Q),
    .commit_v_i     (Commit_V),
    .resp_c         (rs1_resp)
  );

  rename_read_port u_rs2 (
    .addr_i         (rs2_addr),
    .busy_i         (busy_q),
    .tag_i          (tag_q),
    .value_i        (value_q),
    .commit_valid_i (commit_modify_regfile),
    .commit_q_i     (Commit_Q),
    .commit_v_i     (Commit_V),
    .resp_c         (rs2_resp)
  );

  assign rs1_busy     = rs1_resp.busy;
  assign rs1_Q        = rs1_resp.tag;
  assign rs1_V        = rs1_resp.value;
  assign rs2_busy     = rs2_resp.busy;
  assign rs2_Q        = rs2_resp.tag;
  assign rs2_V        = rs2_resp.value;
  assign commit_count = count_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: directed scenarios then random traffic against a reference model.
module tb_rename_regfile;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, commit_reg_addr;
  logic        rs1_busy, rs2_busy, has_issue, commit_modify_regfile, control_hazard;
  logic [3:0]  rs1_Q, rs2_Q, issue_Q, Commit_Q;
  logic [31:0] rs1_V, rs2_V, Commit_V, commit_count;

  always #5 clk_in = ~clk_in;

  rename_regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs1_Q(rs1_Q), .rs1_V(rs1_V),
    .rs2_busy(rs2_busy), .rs2_Q(rs2_Q), .rs2_V(rs2_V),
    .has_issue(has_issue), .issue_rd(issue_rd), .issue_Q(issue_Q),
    .commit_modify_regfile(commit_modify_regfile), .commit_reg_addr(commit_reg_addr),
    .Commit_Q(Commit_Q), .Commit_V(Commit_V),
    .control_hazard(control_hazard), .commit_count(commit_count)
  );

  typedef struct packed {
    logic [36:0] rd1;   // {busy, Q, V}
    logic [36:0] rd2;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: pend[r] is the ROB tag r waits on, 0 when the value is ready.
  int unsigned m_val[32];
  int unsigned m_pend[32];
  int unsigned m_cnt;
  bit          m_valid = 0;

  function automatic logic [36:0] m_read(input int unsigned a, input bit cm,
                                         input int unsigned cq, input int unsigned cv);
    if (a == 0) return 37'd0;
    if (m_pend[a] != 0 && cm && cq == m_pend[a]) return {1'b0, 4'd0, 32'(cv)};
    if (m_pend[a] != 0) return {1'b1, 4'(m_pend[a]), 32'd0};
    return {1'b0, 4'd0, 32'(m_val[a])};
  endfunction

  task automatic cycle(input bit rst, input bit rdy, input int unsigned a1, input int unsigned a2,
                       input bit iss, input int unsigned ird, input int unsigned iq,
                       input bit cm, input int unsigned ca, input int unsigned cq,
                       input int unsigned cv, input bit ch, input string nm);
    exp_t e;
    @(posedge clk_in);
    #1;
    rst_in = rst; rdy_in = rdy; rs1_addr = 5'(a1); rs2_addr = 5'(a2);
    has_issue = iss; issue_rd = 5'(ird); issue_Q = 4'(iq);
    commit_modify_regfile = cm; commit_reg_addr = 5'(ca); Commit_Q = 4'(cq); Commit_V = 32'(cv);
    control_hazard = ch;
    if (m_valid) begin
      e.rd1 = m_read(a1, cm, cq, cv);
      e.rd2 = m_read(a2, cm, cq, cv);
      e.cnt = 32'(m_cnt);
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    // State the next edge will produce.
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_val[r] = 0; m_pend[r] = 0; end
      m_cnt = 0;
      m_valid = 1;
    end else if (rdy) begin
      if (cm) begin
        if (ca != 0) m_val[ca] = cv;
        if (m_pend[ca] == cq) m_pend[ca] = 0;
        m_cnt = m_cnt + 1;
      end
      if (ch) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
      end else if (iss && ird != 0) begin
        m_pend[ird] = iq;
      end
    end
  endtask

  task automatic rd(input int unsigned a1, input int unsigned a2, input string nm);
    cycle(0, 1, a1, a2, 0, 0, 0, 0, 0, 0, 0, 0, nm);
  endtask

  // Monitor: read outputs are valid every cycle; check mid-cycle.
  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if ({rs1_busy, rs1_Q, rs1_V} !== e.rd1) begin
        fails++;
        $display("FAIL %s rs1: got busy=%0b Q=%0d V=%h, want busy=%0b Q=%0d V=%h",
                 nm, rs1_busy, rs1_Q, rs1_V, e.rd1[36], e.rd1[35:32], e.rd1[31:0]);
      end
      tests++;
      if ({rs2_busy, rs2_Q, rs2_V} !== e.rd2) begin
        fails++;
        $display("FAIL %s rs2: got busy=%0b Q=%0d V=%h, want busy=%0b Q=%0d V=%h",
                 nm, rs2_busy, rs2_Q, rs2_V, e.rd2[36], e.rd2[35:32], e.rd2[31:0]);
      end
      tests++;
      if (commit_count !== e.cnt) begin
        fails++;
        $display("FAIL %s commit_count: got %0d want %0d", nm, commit_count, e.cnt);
      end
    end
  end

  initial begin
    rst_in = 1; rdy_in = 0; rs1_addr = 0; rs2_addr = 0; has_issue = 0; issue_rd = 0;
    issue_Q = 0; commit_modify_regfile = 0; commit_reg_addr = 0; Commit_Q = 0; Commit_V = 0;
    control_hazard = 0;

    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
    cycle(1, 0, 5, 5, 1, 5, 3, 1, 5, 3, 7, 0, "reset1");
    rd(5, 0, "after_reset");

    cycle(0, 1, 5, 0, 1, 5, 3, 0, 0, 0, 0, 0, "issue5_own_read");
    rd(5, 6, "x5_busy");
    cycle(0, 1, 5, 0, 0, 0, 0, 1, 5, 3, 32'hDEAD, 0, "x5_bypass");
    rd(5, 5, "x5_committed");

    cycle(0, 1, 0, 0, 1, 7, 2, 0, 0, 0, 0, 0, "issue7_q2");
    cycle(0, 1, 7, 0, 1, 7, 4, 0, 0, 0, 0, 0, "issue7_q4");
    cycle(0, 1, 7, 0, 0, 0, 0, 1, 7, 2, 1, 0, "stale_commit7");
    rd(7, 0, "x7_still_q4");
    cycle(0, 1, 7, 0, 0, 0, 0, 1, 7, 4, 9, 0, "commit7_bypass");
    rd(7, 7, "x7_is_9");

    cycle(0, 1, 0, 0, 1, 9, 6, 1, 9, 5, 32'h11, 0, "issue_commit9");
    rd(9, 0, "x9_busy_q6");
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 9, 6, 32'h22, 0, "commit9_q6");
    rd(9, 0, "x9_is_22");

    cycle(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, "ren_x1");
    cycle(0, 1, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, "ren_x2");
    cycle(0, 1, 1, 2, 1, 3, 3, 0, 0, 0, 0, 0, "ren_x3");
    cycle(0, 1, 3, 0, 1, 4, 5, 1, 6, 9, 32'h66, 1, "flush_with_issue4");
    rd(1, 4, "post_flush_x1_x4");
    rd(2, 3, "post_flush_x2_x3");
    rd(6, 0, "flush_commit_value");

    cycle(0, 1, 0, 0, 1, 0, 7, 1, 0, 7, 32'hFFFF, 0, "x0_issue_commit");
    rd(0, 0, "x0_zero");
    cycle(0, 0, 8, 0, 1, 8, 7, 1, 8, 7, 32'h88, 0, "rdy_low");
    rd(8, 0, "x8_not_busy");

    // Random traffic over a small register window so renames collide often.
    for (int i = 0; i < 600; i++) begin
      bit r, y, iss, cm, ch;
      r   = ($urandom_range(0, 99) == 0);
      y   = ($urandom_range(0, 9) != 0);
      iss = $urandom_range(0, 1) == 1;
      cm  = $urandom_range(0, 1) == 1;
      ch  = ($urandom_range(0, 29) == 0);
      cycle(r, y, $urandom_range(0, 7), $urandom_range(0, 7), iss, $urandom_range(0, 7),
            $urandom_range(1, 15), cm, $urandom_range(0, 7), $urandom_range(1, 15),
            $urandom, ch, "random");
    end

    repeat (3) @(posedge clk_in);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Architectural register file with per-register rename tags for the out-of-order RV32I core. It sits between the issue stage and the ROB commit port. Issue records which ROB slot will produce each destination register. Commit writes retired values and clears tags that are still current. Operand reads return either a ready value or the ROB tag to wait on, and a same-cycle commit is bypassed into the read.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width (32 registers)
- Q_WIDTH, 4, ROB tag width; tag 0 is never a live ROB slot and means "not renamed"

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global enable; low = hold all state, ignore all inputs
- rs1_addr  input  REG_ADDR_WIDTH  operand 1 index
- rs2_addr  input  REG_ADDR_WIDTH  operand 2 index
- rs1_busy  output  1  operand 1 pending in ROB
- rs1_Q  output  Q_WIDTH  producing ROB tag when busy, else 0
- rs1_V  output  32  operand 1 value when not busy, else 0
- rs2_busy / rs2_Q / rs2_V  output  1 / Q_WIDTH / 32  same for operand 2
- has_issue  input  1  an instruction is entering the ROB this cycle
- issue_rd  input  REG_ADDR_WIDTH  its destination register
- issue_Q  input  Q_WIDTH  ROB slot allocated to it (ROB tail)
- commit_modify_regfile  input  1  head entry retires with a register result
- commit_reg_addr  input  REG_ADDR_WIDTH  retiring destination
- Commit_Q  input  Q_WIDTH  retiring ROB slot
- Commit_V  input  32  retiring value
- control_hazard  input  1  mispredict flush from the ROB
- commit_count  output  32  number of register-writing commits since reset

## Operation
- State: value[32] × 32 bits, busy[32], tag[32] × Q_WIDTH, commit_count.
- Register x0 is never written, never busy, and always reads V=0, Q=0, busy=0.
- Issue (has_issue && issue_rd≠0 && !control_hazard): busy[issue_rd]←1, tag[issue_rd]←issue_Q. A newer issue overwrites an older tag.
- Commit (commit_modify_regfile):
  - value[commit_reg_addr]←Commit_V if the address is ≠0.
  - If busy and tag[commit_reg_addr]==Commit_Q, then busy←0 and tag←0.
  - commit_count increments, including for rd=0.
- Issue and commit to the same register in one cycle: the commit value write happens, and the issue rename wins (busy=1, tag=issue_Q).
- Flush (control_hazard): all busy←0 and all tags←0. Any commit value write in the same cycle is still applied and counted. Issue is ignored that cycle.
- Read (combinational) for each port:
  - if addr==0, return 0/0/0;
  - else if busy and commit_modify_regfile and Commit_Q==tag[addr], return busy=0, V=Commit_V, Q=0 (bypass);
  - else if busy, return busy=1, Q=tag, V=0;
  - else return busy=0, V=value, Q=0.
- Reads never see a same-cycle issue. An instruction reading its own rd gets the prior mapping.

## Timing
- Reset: all values, busy, tags and commit_count become 0. Every read output is then 0.
- Reset overrides rdy_in and all other inputs. Reset mid-stream discards all pending renames.
- Issue and commit take effect at the next rising edge. Reads have zero latency.
- rdy_in=0: no state changes, but read outputs still reflect current state plus the commit bypass.
- commit_count wraps modulo 2^32.

## Structure
- Shared package: REG_ADDR_WIDTH, Q_WIDTH, the NO_TAG=0 constant, and the 32-register count. The same package serves the ROB and issue unit.
- One sub-module is natural: rename_read_port (combinational lookup plus bypass), instantiated twice.

## Test plan
- Reset, then read x5 -> busy=0, Q=0, V=0, and commit_count=0.
- Issue rd=5, Q=3; next cycle read x5 -> busy=1, Q=3. Then commit addr=5, Q=3, V=0xDEAD -> same-cycle read gives busy=0, V=0xDEAD; the cycle after, state shows busy=0 and value=0xDEAD.
- Issue rd=7 Q=2, then issue rd=7 Q=4, then commit addr=7 Q=2 V=1 -> value[7]=1 but busy remains with Q=4. Commit Q=4 V=9 -> read 9.
- Issue rd=9 Q=6 and commit addr=9 Q=5 V=0x11 in the same cycle -> value=0x11, busy=1, Q=6.
- Rename x1..x3, then pulse control_hazard together with has_issue rd=4 -> x1..x4 are all not busy, and x4 gets no tag.
- Issue or commit to x0 with V=0xFFFF -> x0 reads 0 and commit_count increments. With rdy_in=0 and issue rd=8 asserted -> x8 stays not busy.
